// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command framer.
package spi_cmd_pkg;

   typedef enum logic [1:0] {IDLE, SEND, COLLECT} state_t;

   // Width of the stall watchdog counter.
   localparam int unsigned WDOG_W = 16;

   // Bytes per frame: header bytes followed by data bytes.
   function automatic int unsigned frame_len(input int unsigned addr_bytes,
                                             input int unsigned data_bytes);
      return addr_bytes + data_bytes;
   endfunction

endpackage

// File: rtl/spi_cmd_framer_if.sv
// Command, byte-stream and response signals of the SPI command framer.
// The master modport is the framer itself; slave is the command source
// and the SPI byte master sitting around it.
interface spi_cmd_framer_if #(
   parameter int unsigned ADDR_BYTES = 1,
   parameter int unsigned DATA_BYTES = 2
);
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic                      cmd_read;
   logic [8*ADDR_BYTES-2:0]   cmd_addr;
   logic [8*DATA_BYTES-1:0]   cmd_wdata;
   logic [7:0]                tx_data;
   logic                      tx_empty;
   logic                      tx_rdreq;
   logic [7:0]                rx_data;
   logic                      rx_wrreq;
   logic [8*DATA_BYTES-1:0]   rsp_data;
   logic                      rsp_valid;
   logic                      done;
   logic                      err;
   logic                      busy;

   modport master (
      input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, tx_rdreq, rx_data, rx_wrreq,
      output cmd_ready, tx_data, tx_empty, rsp_data, rsp_valid, done, err, busy
   );

   modport slave (
      output cmd_valid, cmd_read, cmd_addr, cmd_wdata, tx_rdreq, rx_data, rx_wrreq,
      input  cmd_ready, tx_data, tx_empty, rsp_data, rsp_valid, done, err, busy
   );
endinterface

// File: rtl/spi_cmd_framer.sv
// Turns one register command into a gap-free show-ahead byte stream for the
// SPI byte master, counts returned bytes, assembles read data and aborts
// frames that stall for TIMEOUT cycles.
module spi_cmd_framer
   import spi_cmd_pkg::*;
#(
   parameter int unsigned ADDR_BYTES = 1,
   parameter int unsigned DATA_BYTES = 2,
   parameter int unsigned TIMEOUT    = 1000
) (
   input logic               sys_clk,
   input logic               n_rst,
   spi_cmd_framer_if.master  bus
);

   localparam int unsigned F  = frame_len(ADDR_BYTES, DATA_BYTES);
   localparam int unsigned CW = $clog2(F + 1);
   localparam int unsigned IW = 8 * F;
   localparam int unsigned DW = 8 * DATA_BYTES;

   localparam logic [CW-1:0]     F_CNT   = CW'(F);
   localparam logic [CW-1:0]     A_CNT   = CW'(ADDR_BYTES);
   localparam logic [WDOG_W-1:0] TO_LAST = WDOG_W'(TIMEOUT - 1);

   state_t              state_q;
   logic [IW-1:0]       image_q;
   logic [CW-1:0]       tx_idx_q;
   logic [CW-1:0]       rx_cnt_q;
   logic                rd_flag_q;
   logic [DW-1:0]       rsp_q;
   logic [WDOG_W-1:0]   wdog_q;
   logic                cmd_ready_q;
   logic                rsp_valid_q;
   logic                done_q;
   logic                err_q;

   logic [IW-1:0]       image;
   logic                accept;
   logic                rx_take;
   logic                progress;
   logic                complete;
   logic                stall_abort;

   // Read frames carry zeros in the data bytes.
   assign image = {bus.cmd_read, bus.cmd_addr, bus.cmd_read ? {DW{1'b0}} : bus.cmd_wdata};

   assign accept      = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;
   assign rx_take     = (state_q != IDLE) && bus.rx_wrreq && (rx_cnt_q != F_CNT);
   assign progress    = bus.tx_rdreq || bus.rx_wrreq;
   assign complete    = (state_q == COLLECT) && (tx_idx_q == F_CNT) && (rx_cnt_q == F_CNT);
   // Abort on the edge the counter would reach TIMEOUT; any progress wins.
   assign stall_abort = (state_q != IDLE) && !complete && !progress && (wdog_q == TO_LAST);

   // Frame FSM with counters, image shifter, response shifter and watchdog.
   always_ff @(posedge sys_clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         image_q     <= '0;
         tx_idx_q    <= '0;
         rx_cnt_q    <= '0;
         rd_flag_q   <= 1'b0;
         rsp_q       <= '0;
         wdog_q      <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         err_q       <= 1'b0;

         if (state_q == IDLE || progress) wdog_q <= '0;
         else                             wdog_q <= wdog_q + 1'b1;

         // Header bytes are dropped; data bytes enter at the LSB end on reads.
         if (rx_take) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
            if (rd_flag_q && (rx_cnt_q >= A_CNT)) rsp_q <= DW'({rsp_q, bus.rx_data});
         end

         if (stall_abort) begin
            state_q     <= IDLE;
            image_q     <= '0;
            cmd_ready_q <= 1'b1;
            err_q       <= 1'b1;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (accept) begin
                     state_q     <= SEND;
                     image_q     <= image;
                     rd_flag_q   <= bus.cmd_read;
                     tx_idx_q    <= '0;
                     rx_cnt_q    <= '0;
                     cmd_ready_q <= 1'b0;
                  end else begin
                     cmd_ready_q <= 1'b1;
                  end
               end
               SEND: begin
                  // Shift the image so the next byte shows with no bubble.
                  if (bus.tx_rdreq) begin
                     tx_idx_q <= tx_idx_q + 1'b1;
                     image_q  <= IW'({image_q, 8'h00});
                     if (tx_idx_q == F_CNT - 1'b1) state_q <= COLLECT;
                  end
               end
               COLLECT: begin
                  if (complete) begin
                     state_q     <= IDLE;
                     cmd_ready_q <= 1'b1;
                     done_q      <= 1'b1;
                     rsp_valid_q <= rd_flag_q;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.tx_data   = image_q[IW-1 -: 8];
   assign bus.tx_empty  = (state_q != SEND);
   assign bus.rsp_data  = rsp_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_framer.sv
// Directed bench for spi_cmd_framer: table of full frames plus hand-written
// back-to-back, stall, timeout and mid-frame reset sequences.
module tb_spi_cmd_framer;

   logic sys_clk = 1'b0;
   logic n_rst   = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Shared stimulus, steered to one of two instances.
   logic        sel_b     = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_read  = 1'b0;
   logic [6:0]  cmd_addr  = '0;
   logic [15:0] cmd_wdata = '0;
   logic        tx_rdreq  = 1'b0;
   logic [7:0]  rx_data   = '0;
   logic        rx_wrreq  = 1'b0;

   spi_cmd_framer_if #(.ADDR_BYTES(1), .DATA_BYTES(2)) ifa ();
   spi_cmd_framer_if #(.ADDR_BYTES(1), .DATA_BYTES(2)) ifb ();

   spi_cmd_framer #(.ADDR_BYTES(1), .DATA_BYTES(2), .TIMEOUT(1000)) dut_a (
      .sys_clk (sys_clk),
      .n_rst   (n_rst),
      .bus     (ifa.master)
   );

   spi_cmd_framer #(.ADDR_BYTES(1), .DATA_BYTES(2), .TIMEOUT(16)) dut_b (
      .sys_clk (sys_clk),
      .n_rst   (n_rst),
      .bus     (ifb.master)
   );

   assign ifa.cmd_valid = sel_b ? 1'b0 : cmd_valid;
   assign ifa.cmd_read  = cmd_read;
   assign ifa.cmd_addr  = cmd_addr;
   assign ifa.cmd_wdata = cmd_wdata;
   assign ifa.tx_rdreq  = sel_b ? 1'b0 : tx_rdreq;
   assign ifa.rx_data   = rx_data;
   assign ifa.rx_wrreq  = sel_b ? 1'b0 : rx_wrreq;
   assign ifb.cmd_valid = sel_b ? cmd_valid : 1'b0;
   assign ifb.cmd_read  = cmd_read;
   assign ifb.cmd_addr  = cmd_addr;
   assign ifb.cmd_wdata = cmd_wdata;
   assign ifb.tx_rdreq  = sel_b ? tx_rdreq : 1'b0;
   assign ifb.rx_data   = rx_data;
   assign ifb.rx_wrreq  = sel_b ? rx_wrreq : 1'b0;

   logic        o_ready, o_empty, o_rv, o_done, o_err, o_busy;
   logic [7:0]  o_tx;
   logic [15:0] o_rsp;
   assign o_ready = sel_b ? ifb.cmd_ready : ifa.cmd_ready;
   assign o_empty = sel_b ? ifb.tx_empty  : ifa.tx_empty;
   assign o_tx    = sel_b ? ifb.tx_data   : ifa.tx_data;
   assign o_rsp   = sel_b ? ifb.rsp_data  : ifa.rsp_data;
   assign o_rv    = sel_b ? ifb.rsp_valid : ifa.rsp_valid;
   assign o_done  = sel_b ? ifb.done      : ifa.done;
   assign o_err   = sel_b ? ifb.err       : ifa.err;
   assign o_busy  = sel_b ? ifb.busy      : ifa.busy;

   int    total = 0;
   int    bad   = 0;
   string scen  = "reset";

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s/%s: got 0x%0h want 0x%0h", scen, name, act, exp);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_ready", 32'(o_ready), 32'h0);
      check("rst_empty", 32'(o_empty), 32'h1);
      check("rst_tx",    32'(o_tx),    32'h0);
      check("rst_rsp",   32'(o_rsp),   32'h0);
      check("rst_rv",    32'(o_rv),    32'h0);
      check("rst_done",  32'(o_done),  32'h0);
      check("rst_err",   32'(o_err),   32'h0);
      check("rst_busy",  32'(o_busy),  32'h0);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after accept.
   task automatic start(input logic rd, input logic [6:0] addr, input logic [15:0] wd,
                        input logic keep_valid);
      check("pre_ready", 32'(o_ready), 32'h1);
      cmd_valid = 1'b1;
      cmd_read  = rd;
      cmd_addr  = addr;
      cmd_wdata = wd;
      @(negedge sys_clk);
      if (!keep_valid) cmd_valid = 1'b0;
      check("acc_busy",  32'(o_busy),  32'h1);
      check("acc_ready", 32'(o_ready), 32'h0);
   endtask

   // Consumes three bytes (optional stall after byte 0), returns one rx byte
   // with each consume, then checks completion; returns at the done negedge.
   task automatic xfer(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                       input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                       input logic exp_rv, input logic [15:0] exp_rsp, input int gap);
      logic [7:0] t [3];
      logic [7:0] r [3];
      t = '{t0, t1, t2};
      r = '{r0, r1, r2};
      for (int i = 0; i < 3; i++) begin
         check("tx_empty", 32'(o_empty), 32'h0);
         check("tx_data",  32'(o_tx),    32'(t[i]));
         check("ready_lo", 32'(o_ready), 32'h0);
         tx_rdreq = 1'b1;
         rx_wrreq = 1'b1;
         rx_data  = r[i];
         @(negedge sys_clk);
         if (i == 0 && gap > 0) begin
            tx_rdreq = 1'b0;
            rx_wrreq = 1'b0;
            for (int g = 0; g < gap; g++) begin
               check("stall_tx",    32'(o_tx),    32'(t[1]));
               check("stall_empty", 32'(o_empty), 32'h0);
               check("stall_err",   32'(o_err),   32'h0);
               @(negedge sys_clk);
            end
         end
      end
      tx_rdreq = 1'b0;
      rx_wrreq = 1'b0;
      check("coll_empty", 32'(o_empty), 32'h1);
      check("coll_busy",  32'(o_busy),  32'h1);
      check("coll_done",  32'(o_done),  32'h0);
      check("coll_ready", 32'(o_ready), 32'h0);
      @(negedge sys_clk);
      check("done",      32'(o_done),  32'h1);
      check("rsp_valid", 32'(o_rv),    32'(exp_rv));
      check("rsp_data",  32'(o_rsp),   32'(exp_rsp));
      check("end_ready", 32'(o_ready), 32'h1);
      check("end_busy",  32'(o_busy),  32'h0);
   endtask

   task automatic after_done(input logic [15:0] exp_rsp);
      @(negedge sys_clk);
      check("done_pulse", 32'(o_done), 32'h0);
      check("rv_pulse",   32'(o_rv),   32'h0);
      check("rsp_hold",   32'(o_rsp),  32'(exp_rsp));
   endtask

   typedef struct {
      logic        rd;
      logic [6:0]  addr;
      logic [15:0] wdata;
      logic [7:0]  t0, t1, t2;
      logic [7:0]  r0, r1, r2;
      logic        rv;
      logic [15:0] rsp;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{1'b0, 7'h15, 16'hA55A, 8'h15, 8'hA5, 8'h5A, 8'h00, 8'h11, 8'h22, 1'b0, 16'h0000};
      vecs[1] = '{1'b1, 7'h05, 16'h0000, 8'h85, 8'h00, 8'h00, 8'hFF, 8'h12, 8'h34, 1'b1, 16'h1234};
      vecs[2] = '{1'b0, 7'h7F, 16'h0102, 8'h7F, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'hCC, 1'b0, 16'h1234};
      vecs[3] = '{1'b1, 7'h7F, 16'hBEEF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hCA, 8'hFE, 1'b1, 16'hCAFE};
      vecs[4] = '{1'b1, 7'h00, 16'h0000, 8'h80, 8'h00, 8'h00, 8'h12, 8'h00, 8'h01, 1'b1, 16'h0001};

      @(negedge sys_clk);
      check_reset_outputs();
      n_rst = 1'b1;
      @(negedge sys_clk);
      check("rel_ready", 32'(o_ready), 32'h1);
      check("rel_empty", 32'(o_empty), 32'h1);
      check("rel_busy",  32'(o_busy),  32'h0);

      for (int i = 0; i < 5; i++) begin
         scen = $sformatf("vec%0d", i);
         start(vecs[i].rd, vecs[i].addr, vecs[i].wdata, 1'b0);
         xfer(vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].r0, vecs[i].r1, vecs[i].r2,
              vecs[i].rv, vecs[i].rsp, 0);
         after_done(vecs[i].rsp);
      end

      // cmd_valid held across two commands: second accepted the edge after done.
      scen = "back2back";
      start(1'b0, 7'h21, 16'h1357, 1'b1);
      cmd_read  = 1'b1;
      cmd_addr  = 7'h33;
      cmd_wdata = 16'hFFFF;
      xfer(8'h21, 8'h13, 8'h57, 8'h01, 8'h02, 8'h03, 1'b0, 16'h0001, 0);
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      check("b_busy",  32'(o_busy),  32'h1);
      check("b_empty", 32'(o_empty), 32'h0);
      check("b_ready", 32'(o_ready), 32'h0);
      check("b_done",  32'(o_done),  32'h0);
      xfer(8'hB3, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hC3, 1'b1, 16'h5AC3, 0);
      after_done(16'h5AC3);

      // Master withholds rdreq for 10 cycles after byte 0.
      scen = "withhold";
      start(1'b0, 7'h42, 16'hDEAD, 1'b0);
      xfer(8'h42, 8'hDE, 8'hAD, 8'h10, 8'h20, 8'h30, 1'b0, 16'h5AC3, 10);
      after_done(16'h5AC3);

      // TIMEOUT=16 instance: all bytes consumed, only two rx bytes return.
      scen  = "timeout";
      sel_b = 1'b1;
      start(1'b0, 7'h11, 16'h2233, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("to_tx", 32'(o_tx), (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : 32'h33);
         tx_rdreq = 1'b1;
         @(negedge sys_clk);
      end
      tx_rdreq = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rx_wrreq = 1'b1;
         rx_data  = 8'h40 + 8'(i);
         @(negedge sys_clk);
      end
      rx_wrreq = 1'b0;
      for (int j = 1; j < 16; j++) begin
         @(negedge sys_clk);
         check("to_wait_err",  32'(o_err),  32'h0);
         check("to_wait_busy", 32'(o_busy), 32'h1);
      end
      @(negedge sys_clk);
      check("to_err",   32'(o_err),   32'h1);
      check("to_done",  32'(o_done),  32'h0);
      check("to_rv",    32'(o_rv),    32'h0);
      check("to_busy",  32'(o_busy),  32'h0);
      check("to_empty", 32'(o_empty), 32'h1);
      check("to_ready", 32'(o_ready), 32'h1);
      @(negedge sys_clk);
      check("to_err_pulse", 32'(o_err), 32'h0);
      scen = "after_timeout";
      start(1'b1, 7'h05, 16'h0000, 1'b0);
      xfer(8'h85, 8'h00, 8'h00, 8'hFF, 8'h12, 8'h34, 1'b1, 16'h1234, 0);
      after_done(16'h1234);
      sel_b = 1'b0;
      @(negedge sys_clk);

      // Reset lands after byte 1 has been consumed.
      scen = "midreset";
      start(1'b1, 7'h0A, 16'h0000, 1'b0);
      check("mr_tx0", 32'(o_tx), 32'h8A);
      tx_rdreq = 1'b1;
      rx_wrreq = 1'b1;
      rx_data  = 8'h99;
      @(negedge sys_clk);
      check("mr_tx1", 32'(o_tx), 32'h00);
      rx_data = 8'h77;
      @(negedge sys_clk);
      tx_rdreq = 1'b0;
      rx_wrreq = 1'b0;
      n_rst    = 1'b0;
      #1;
      check_reset_outputs();
      @(negedge sys_clk);
      check("mr_hold_ready", 32'(o_ready), 32'h0);
      n_rst = 1'b1;
      @(negedge sys_clk);
      check("mr_ready", 32'(o_ready), 32'h1);
      check("mr_empty", 32'(o_empty), 32'h1);
      scen = "after_reset";
      start(1'b1, 7'h05, 16'h0000, 1'b0);
      xfer(8'h85, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hCD, 1'b1, 16'hABCD, 0);
      after_done(16'hABCD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "bench did not finish");
   end

endmodule
